mem_ctrl_fsm: RTL and testbench

Parametrised successor to the single-bit memory select/op/rw/valid controller. It accepts one read or write request at a time on a sel/op strobe and owns an internal DEPTH x DATA_W register-array memory. It inserts a programmable number of read wait states and reports completion with a one-cycle valid pulse, with rw qualifying the direction. It sits between the datapath request logic and the on-chip storage of the memory subsystem.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_ctrl_fsm_wait_counter.sv | 27 ++
 rtl/mem_ctrl_fsm.sv | 125 ++++++++++++
 tb/tb_mem_ctrl_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory controller: FSM state type and op codes.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WRITE   = 2'b01,
    RD_WAIT = 2'b10,
    RD_DONE = 2'b11
  } state_t;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

endpackage

// File: rtl/mem_ctrl_fsm_wait_counter.sv
// Loadable down-counter with enable and zero flag, used to time read wait states.
module wait_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_ctrl_fsm.sv
// Single-request memory controller with internal register-array storage and read wait states.
// Define PARITY_EN to add per-word even parity storage and the perr output.
module mem_ctrl_fsm
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rw,
  output logic              valid,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              err
`ifdef PARITY_EN
  ,
  output logic              perr
`endif
);

  localparam int unsigned          CNT_W    = $clog2(RD_LAT) + 1;
  localparam logic [CNT_W-1:0]     LOAD_VAL = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W:0]      DEPTH_L  = (ADDR_W + 1)'(DEPTH);
`ifdef PARITY_EN
  localparam int unsigned          MEM_W    = DATA_W + 1;
`else
  localparam int unsigned          MEM_W    = DATA_W;
`endif

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q;
  logic [MEM_W-1:0]    mem [DEPTH];
  logic [MEM_W-1:0]    rd_word, wr_word;
  logic                accept, in_range_d, in_range_q;
  logic                cnt_load, cnt_en, cnt_zero;
  logic                rw_d, valid_d, busy_d, err_d;
  logic [DATA_W-1:0]   rdata_d;
`ifdef PARITY_EN
  logic                perr_d;
  assign wr_word = {^wdata_q, wdata_q};
`else
  assign wr_word = wdata_q;
`endif

  assign accept     = (state == IDLE) && sel;
  assign addr_d     = accept ? addr : addr_q;
  assign in_range_d = ({1'b0, addr_d} < DEPTH_L);
  assign in_range_q = ({1'b0, addr_q} < DEPTH_L);
  assign rd_word    = in_range_q ? mem[addr_q] : '0;
  assign cnt_load   = accept && (op == OP_READ);
  assign cnt_en     = (state == RD_WAIT) && !cnt_zero;

  wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  // Outputs are decoded from the next state so they are registered yet line up with it.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (sel) state_d = (op == OP_READ) ? RD_WAIT : WRITE;
      WRITE:   state_d = IDLE;
      RD_WAIT: if (cnt_zero) state_d = RD_DONE;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == WRITE) || (state_d == RD_DONE);
    busy_d  = (state_d != IDLE);
    rw_d    = (state_d == RD_WAIT) || (state_d == RD_DONE);
    err_d   = valid_d && !in_range_d;
    rdata_d = (state_d == RD_DONE) ? rd_word[DATA_W-1:0] : rdata;
`ifdef PARITY_EN
    perr_d  = (state_d == RD_DONE) && in_range_q && (^rd_word);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rw      <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
`ifdef PARITY_EN
      perr    <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      if (accept) wdata_q <= wdata;
      rw      <= rw_d;
      valid   <= valid_d;
      busy    <= busy_d;
      err     <= err_d;
      rdata   <= rdata_d;
`ifdef PARITY_EN
      perr    <= perr_d;
`endif
    end
  end

  // Storage commits at the edge closing WRITE; an async reset before then aborts it.
  always_ff @(posedge clk) begin
    if ((state == WRITE) && in_range_q) begin
      mem[addr_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Directed bench for mem_ctrl_fsm: three instances (DEPTH/RD_LAT variants) driven in lockstep.
module tb_mem_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n, sel, op;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [2:0] rw, valid, busy, err;
  logic [7:0] rdata [3];
`ifdef PARITY_EN
  logic [2:0] perr;
`endif

  always #5 clk = ~clk;

  mem_ctrl_fsm #(.ADDR_W(4), .DATA_W(8), .DEPTH(10), .RD_LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .op(op), .addr(addr), .wdata(wdata),
    .rw(rw[0]), .valid(valid[0]), .busy(busy[0]), .rdata(rdata[0]), .err(err[0])
`ifdef PARITY_EN
    , .perr(perr[0])
`endif
  );

  mem_ctrl_fsm #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .op(op), .addr(addr), .wdata(wdata),
    .rw(rw[1]), .valid(valid[1]), .busy(busy[1]), .rdata(rdata[1]), .err(err[1])
`ifdef PARITY_EN
    , .perr(perr[1])
`endif
  );

  mem_ctrl_fsm #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LAT(4)) u2 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .op(op), .addr(addr), .wdata(wdata),
    .rw(rw[2]), .valid(valid[2]), .busy(busy[2]), .rdata(rdata[2]), .err(err[2])
`ifdef PARITY_EN
    , .perr(perr[2])
`endif
  );

  typedef struct {
    logic       op;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp0;   // read data expected from u0 (DEPTH=10)
    logic       err0;   // err expected from u0
    logic [7:0] exp1;   // read data expected from u1/u2 (DEPTH=16)
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  int         rdl [3] = '{2, 1, 4};
  logic [7:0] last_rd [3] = '{8'h00, 8'h00, 8'h00};
  vec_t       vecs [14];

  logic       t_v  [3][11];
  logic       t_b  [3][11];
  logic       t_rw [3][11];
  logic       t_e  [3][11];
  logic [7:0] t_d  [3][11];
`ifdef PARITY_EN
  logic       t_p  [3][11];
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sample(input int k);
    for (int i = 0; i < 3; i++) begin
      t_v[i][k]  = valid[i];
      t_b[i][k]  = busy[i];
      t_rw[i][k] = rw[i];
      t_e[i][k]  = err[i];
      t_d[i][k]  = rdata[i];
`ifdef PARITY_EN
      t_p[i][k]  = perr[i];
`endif
    end
  endtask

  // Present one request for a single edge, optionally inject a second request on the
  // following edge, and record ten cycles of outputs starting with the cycle after accept.
  task automatic run_req(input logic o, input logic [3:0] a, input logic [7:0] d,
                         input logic inj, input logic io, input logic [3:0] ia,
                         input logic [7:0] id);
    @(negedge clk);
    sel = 1'b1; op = o; addr = a; wdata = d;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 1 && inj) begin
        sel = 1'b1; op = io; addr = ia; wdata = id;
      end else begin
        sel = 1'b0;
      end
    end
  endtask

  task automatic analyze(input int i, output int fv, output int nv, output int nb);
    fv = 0; nv = 0; nb = 0;
    for (int k = 1; k <= 10; k++) begin
      if (t_v[i][k]) begin
        nv++;
        if (fv == 0) fv = k;
      end
      if (t_b[i][k]) nb++;
    end
  endtask

  initial begin
    int fv, nv, nb, lat, idx, nvr;
    vec_t v;

    vecs[0]  = '{1'b0, 4'd3,  8'hA5, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 4'd3,  8'h00, 8'hA5, 1'b0, 8'hA5};
    vecs[2]  = '{1'b0, 4'd5,  8'h3C, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 4'd4,  8'hC3, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 4'd12, 8'h77, 8'h00, 1'b1, 8'h00};
    vecs[5]  = '{1'b1, 4'd12, 8'h00, 8'h00, 1'b1, 8'h77};
    vecs[6]  = '{1'b1, 4'd4,  8'h00, 8'hC3, 1'b0, 8'hC3};
    vecs[7]  = '{1'b1, 4'd5,  8'h00, 8'h3C, 1'b0, 8'h3C};
    vecs[8]  = '{1'b0, 4'd9,  8'hFF, 8'h00, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 4'd9,  8'h00, 8'hFF, 1'b0, 8'hFF};
    vecs[10] = '{1'b0, 4'd10, 8'hEE, 8'h00, 1'b1, 8'h00};
    vecs[11] = '{1'b1, 4'd10, 8'h00, 8'h00, 1'b1, 8'hEE};
    vecs[12] = '{1'b0, 4'd0,  8'h5A, 8'h00, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 4'd0,  8'h00, 8'h5A, 1'b0, 8'h5A};

    rst_n = 1'b0; sel = 1'b0; op = 1'b0; addr = '0; wdata = '0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_rw[%0d]", i),    32'(rw[i]),    32'd0);
      chk($sformatf("reset_valid[%0d]", i), 32'(valid[i]), 32'd0);
      chk($sformatf("reset_busy[%0d]", i),  32'(busy[i]),  32'd0);
      chk($sformatf("reset_err[%0d]", i),   32'(err[i]),   32'd0);
      chk($sformatf("reset_rdata[%0d]", i), 32'(rdata[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 14; n++) begin
      v = vecs[n];
      run_req(v.op, v.addr, v.wdata, 1'b0, 1'b0, 4'd0, 8'h00);
      for (int i = 0; i < 3; i++) begin
        lat = v.op ? rdl[i] + 1 : 1;
        analyze(i, fv, nv, nb);
        idx = (fv == 0) ? 1 : fv;
        chk($sformatf("v%0d_lat[%0d]", n, i),    32'(fv), 32'(lat));
        chk($sformatf("v%0d_nvalid[%0d]", n, i), 32'(nv), 32'd1);
        chk($sformatf("v%0d_busy[%0d]", n, i),   32'(nb), 32'(lat));
        chk($sformatf("v%0d_rw[%0d]", n, i),     32'(t_rw[i][idx]), 32'(v.op));
        chk($sformatf("v%0d_err[%0d]", n, i),    32'(t_e[i][idx]), 32'((i == 0) ? v.err0 : 1'b0));
        if (v.op) begin
          last_rd[i] = (i == 0) ? v.exp0 : v.exp1;
          chk($sformatf("v%0d_rdata[%0d]", n, i), 32'(t_d[i][idx]), 32'(last_rd[i]));
        end else begin
          chk($sformatf("v%0d_rdata_hold[%0d]", n, i), 32'(t_d[i][10]), 32'(last_rd[i]));
        end
      end
    end

    // Write request presented while a read is in flight must be dropped.
    run_req(1'b1, 4'd3, 8'h00, 1'b1, 1'b0, 4'd5, 8'h11);
    for (int i = 0; i < 3; i++) begin
      analyze(i, fv, nv, nb);
      idx = (fv == 0) ? 1 : fv;
      chk($sformatf("drop_nvalid[%0d]", i), 32'(nv), 32'd1);
      chk($sformatf("drop_rdata[%0d]", i),  32'(t_d[i][idx]), 32'hA5);
    end
    run_req(1'b1, 4'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      analyze(i, fv, nv, nb);
      idx = (fv == 0) ? 1 : fv;
      chk($sformatf("drop_readback[%0d]", i), 32'(t_d[i][idx]), 32'h3C);
    end

    // A read presented during the write's valid cycle must not be accepted.
    run_req(1'b0, 4'd7, 8'h42, 1'b1, 1'b1, 4'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      analyze(i, fv, nv, nb);
      chk($sformatf("selvalid_nvalid[%0d]", i), 32'(nv), 32'd1);
      chk($sformatf("selvalid_busy[%0d]", i),   32'(nb), 32'd1);
    end
    run_req(1'b1, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    analyze(0, fv, nv, nb);
    idx = (fv == 0) ? 1 : fv;
    chk("raw_rdata[0]", 32'(t_d[0][idx]), 32'h42);

    // Reset asserted in the middle of a u0 read.
    @(negedge clk);
    sel = 1'b1; op = 1'b1; addr = 4'd3;
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
    chk("midread_busy_pre", 32'(busy[0]), 32'd1);
    chk("midread_rw_pre",   32'(rw[0]),   32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midread_rw",    32'(rw[0]),    32'd0);
    chk("midread_valid", 32'(valid[0]), 32'd0);
    chk("midread_busy",  32'(busy[0]),  32'd0);
    chk("midread_err",   32'(err[0]),   32'd0);
    chk("midread_rdata", 32'(rdata[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nvr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid[0]) nvr++;
    end
    chk("midread_no_valid", 32'(nvr), 32'd0);

`ifdef PARITY_EN
    run_req(1'b0, 4'd2, 8'h0F, 1'b0, 1'b0, 4'd0, 8'h00);
    run_req(1'b1, 4'd2, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    analyze(0, fv, nv, nb);
    idx = (fv == 0) ? 1 : fv;
    chk("parity_clean_perr",  32'(t_p[0][idx]), 32'd0);
    chk("parity_clean_rdata", 32'(t_d[0][idx]), 32'h0F);
    u0.mem[2][0] = ~u0.mem[2][0];
    run_req(1'b1, 4'd2, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    analyze(0, fv, nv, nb);
    idx = (fv == 0) ? 1 : fv;
    chk("parity_flip_perr",  32'(t_p[0][idx]), 32'd1);
    chk("parity_flip_rdata", 32'(t_d[0][idx]), 32'h0E);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
